// File: rtl/register_file_if.sv
// Register-file access bus: two read ports (ID stage) and one write port (WB stage).
// The master drives indices and write data; the register file (slave) returns read data.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: $zero hardwired, two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward a same-cycle WB write onto the read ports.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    register_file_if.slave rf
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              we_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // True when a write in flight targets addr and may be forwarded to a reader
    function automatic logic bypass_hit(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr
    );
`ifdef REGFILE_BYPASS_EN
        return we && (addr == waddr);
`else
        return 1'b0 & we & (addr == waddr);
`endif
    endfunction

    // Effective write enable: writes to $zero are dropped here
    always_comb begin
        we_s = 1'b0;
        if (rf.RegWrite && (rf.WriteReg != {ADDR_W{1'b0}})) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Register storage; entry 0 is never written so it stays 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we_s) begin
            regs_r[rf.WriteReg] <= rf.WriteData;
        end
    end

    // Read port 1: $zero, then bypass, then stored value
    always_comb begin
        rd1_s = {DATA_W{1'b0}};
        if (rf.ReadReg1 == {ADDR_W{1'b0}}) begin
            rd1_s = {DATA_W{1'b0}};
        end else if (bypass_hit(rf.ReadReg1, we_s, rf.WriteReg)) begin
            rd1_s = rf.WriteData;
        end else begin
            rd1_s = regs_r[rf.ReadReg1];
        end
    end

    // Read port 2: same priority as port 1, fully independent
    always_comb begin
        rd2_s = {DATA_W{1'b0}};
        if (rf.ReadReg2 == {ADDR_W{1'b0}}) begin
            rd2_s = {DATA_W{1'b0}};
        end else if (bypass_hit(rf.ReadReg2, we_s, rf.WriteReg)) begin
            rd2_s = rf.WriteData;
        end else begin
            rd2_s = regs_r[rf.ReadReg2];
        end
    end

    assign rf.ReadData1 = rd1_s;
    assign rf.ReadData2 = rd2_s;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array model plus directed vectors.
// Build with REGFILE_BYPASS_EN defined to exercise the bypass configuration.
module tb_register_file;

    logic clk = 1'b0;
    logic reset_n;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] mdl [32];
    logic [31:0] exp_bypass;

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Architectural model: what the registers hold by the ISA's rules
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mdl[i] <= 32'h0;
        end else if (bus.RegWrite === 1'b1 && bus.WriteReg != 5'd0) begin
            mdl[bus.WriteReg] <= bus.WriteData;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (reset_n !== 1'b1) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite === 1'b1 && bus.WriteReg == addr) return bus.WriteData;
`endif
        return mdl[addr];
    endfunction

    // Every falling edge: both read ports against the model
    always @(negedge clk) begin
        if (reset_n !== 1'bx) begin
            check("port1_model", bus.ReadData1, model_read(bus.ReadReg1));
            check("port2_model", bus.ReadData2, model_read(bus.ReadReg2));
        end
    end

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = idx;
        bus.WriteData = val;
        @(posedge clk);
        #1;
        bus.RegWrite  = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.ReadReg1  = 5'd0;
        bus.ReadReg2  = 5'd0;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd5;
        bus.WriteData = 32'hDEADBEEF;

        // 1: write during reset is dropped
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd5;
        #1;
        check("reset_drops_write", bus.ReadData1, 32'h0);
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            bus.ReadReg1 = i[4:0];
            bus.ReadReg2 = 5'(31 - i + 1);
            #1;
            check("reset_entry_p1", bus.ReadData1, 32'h0);
            check("reset_entry_p2", bus.ReadData2, 32'h0);
        end

        // 2: both ports read the same register
        bus.ReadReg1 = 5'd8;
        bus.ReadReg2 = 5'd8;
        write_reg(5'd8, 32'h0000_00AA);
        #1;
        check("dual_read_p1", bus.ReadData1, 32'h0000_00AA);
        check("dual_read_p2", bus.ReadData2, 32'h0000_00AA);

        // 3: $zero ignores writes, with or without bypass
        bus.ReadReg1  = 5'd0;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd0;
        bus.WriteData = 32'hFFFF_FFFF;
        #1;
        check("zero_before_edge", bus.ReadData1, 32'h0);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        #1;
        check("zero_after_edge", bus.ReadData1, 32'h0);

        // 4: RegWrite=0 leaves contents alone
        write_reg(5'd9, 32'h0000_0011);
        bus.WriteReg  = 5'd9;
        bus.WriteData = 32'h0000_0022;
        bus.ReadReg2  = 5'd9;
        @(posedge clk);
        #1;
        check("no_write_holds", bus.ReadData2, 32'h0000_0011);

        // Independent ports on different registers, full-width pattern
        write_reg(5'd31, 32'hA5A5_5A5A);
        bus.ReadReg1 = 5'd31;
        bus.ReadReg2 = 5'd8;
        #1;
        check("indep_p1", bus.ReadData1, 32'hA5A5_5A5A);
        check("indep_p2", bus.ReadData2, 32'h0000_00AA);

        // 5: WB->ID same-cycle hazard
        write_reg(5'd10, 32'h0000_0001);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd10;
        bus.WriteData = 32'h0000_0002;
        bus.ReadReg1  = 5'd10;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h0000_0002;
`else
        exp_bypass = 32'h0000_0001;
`endif
        check("hazard_before_edge", bus.ReadData1, exp_bypass);
        check("hazard_other_port", bus.ReadData2, 32'h0000_00AA);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        #1;
        check("hazard_after_edge", bus.ReadData1, 32'h0000_0002);

        // 6: asynchronous reset between edges
        write_reg(5'd3, 32'h0000_0033);
        bus.ReadReg1 = 5'd3;
        bus.ReadReg2 = 5'd31;
        #1;
        check("pre_reset_value", bus.ReadData1, 32'h0000_0033);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_p1", bus.ReadData1, 32'h0);
        check("async_reset_p2", bus.ReadData2, 32'h0);
        @(posedge clk);
        #1;
        check("reset_held", bus.ReadData1, 32'h0);
        reset_n = 1'b1;
        #1;
        check("after_release", bus.ReadData2, 32'h0);
        write_reg(5'd3, 32'h1234_5678);
        #1;
        check("write_after_reset", bus.ReadData1, 32'h1234_5678);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
